miss_entry_alloc: RTL

- Allocator and tracker for outstanding cache-line misses. It sits directly in front of the miss-address CAM.
- Drives the CAM lookup key and consumes its hit/index outputs. It owns the CAM update port, issuing allocate and invalidate writes.
- Merges duplicate misses into one entry, issues one request per line to L2 with a valid/ready handshake, and releases the entry and wakes all waiting threads on fill.

---
 rtl/miss_entry_alloc_pkg.sv | 18 +
 rtl/miss_issue_arbiter.sv | 57 +++++
 rtl/miss_entry_alloc.sv | 167 ++++++++++++++++
 3 files changed

// File: rtl/miss_entry_alloc_pkg.sv
// Shared types and sizing for the miss entry allocator: entry state, entry record, table geometry.
package miss_entry_alloc_pkg;
  localparam int MISS_ENTRIES          = 4;
  localparam int CACHE_LINE_ADDR_WIDTH = 26;
  localparam int MISS_THREADS          = 4;

  typedef enum logic [1:0] {
    FREE       = 2'd0,
    WAIT_ISSUE = 2'd1,
    PENDING    = 2'd2
  } miss_entry_state_t;

  typedef struct packed {
    miss_entry_state_t                state;
    logic [CACHE_LINE_ADDR_WIDTH-1:0] addr;
    logic [MISS_THREADS-1:0]          waiters;
  } miss_entry_t;
endpackage

// File: rtl/miss_issue_arbiter.sv
// Round-robin arbiter over WAIT_ISSUE entries; the grant is locked while the L2 request stalls
// so the presented address cannot change until accepted. Pointer moves past the winner on update.
module miss_issue_arbiter #(
  parameter int N  = 4,
  parameter int IW = $clog2(N)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] req,
  input  logic         update,
  output logic [N-1:0] grant
);
  logic [IW-1:0] ptr_q, ptr_d;
  logic          lock_q, lock_d;
  logic [N-1:0]  held_q, held_d;
  logic [N-1:0]  rr_grant;
  logic [IW-1:0] idx;
  logic          found;

  always_comb begin
    rr_grant = '0;
    found    = 1'b0;
    idx      = '0;
    for (int i = 0; i < N; i++) begin
      idx = IW'((int'(ptr_q) + i) % N);
      if (!found && req[idx]) begin
        rr_grant[idx] = 1'b1;
        found         = 1'b1;
      end
    end
    grant  = lock_q ? held_q : rr_grant;
    ptr_d  = ptr_q;
    lock_d = lock_q;
    held_d = held_q;
    if (update) begin
      lock_d = 1'b0;
      for (int i = 0; i < N; i++) begin
        if (grant[i]) ptr_d = IW'((i + 1) % N);
      end
    end else if (|grant) begin
      lock_d = 1'b1;
      held_d = grant;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr_q  <= '0;
      lock_q <= 1'b0;
      held_q <= '0;
    end else begin
      ptr_q  <= ptr_d;
      lock_q <= lock_d;
      held_q <= held_d;
    end
  end
endmodule

// File: rtl/miss_entry_alloc.sv
// Miss entry allocator/tracker in front of the miss-address CAM; merges duplicates, one L2 request per line.
// Optional perf pulses and stall counter under MISS_ALLOC_PERF_EN (tied 0 otherwise).
module miss_entry_alloc
  import miss_entry_alloc_pkg::*;
#(
  parameter int NUM_ENTRIES = MISS_ENTRIES,
  parameter int ADDR_WIDTH  = CACHE_LINE_ADDR_WIDTH,
  parameter int THREADS     = MISS_THREADS,
  parameter int INDEX_WIDTH = $clog2(NUM_ENTRIES)
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       miss_en,
  input  logic [ADDR_WIDTH-1:0]      miss_addr,
  input  logic [$clog2(THREADS)-1:0] miss_thread,
  output logic                       miss_ready,
  output logic [ADDR_WIDTH-1:0]      cam_lookup_key,
  input  logic                       cam_lookup_hit,
  input  logic [INDEX_WIDTH-1:0]     cam_lookup_idx,
  output logic                       cam_update_en,
  output logic [ADDR_WIDTH-1:0]      cam_update_key,
  output logic [INDEX_WIDTH-1:0]     cam_update_idx,
  output logic                       cam_update_valid,
  output logic                       l2_req_valid,
  output logic [ADDR_WIDTH-1:0]      l2_req_addr,
  output logic [INDEX_WIDTH-1:0]     l2_req_idx,
  input  logic                       l2_req_ready,
  input  logic                       fill_en,
  input  logic [INDEX_WIDTH-1:0]     fill_idx,
  output logic                       wake_en,
  output logic [THREADS-1:0]         wake_bitmap,
  output logic                       full,
  output logic                       perf_miss_merge,
  output logic                       perf_miss_alloc,
  output logic [31:0]                perf_miss_stall_count
);
  miss_entry_t              entries_q [NUM_ENTRIES];
  miss_entry_t              entries_d [NUM_ENTRIES];
  logic                     wake_en_q, wake_en_d;
  logic [THREADS-1:0]       wake_bitmap_q, wake_bitmap_d;
  logic                     any_free;
  logic [INDEX_WIDTH-1:0]   free_idx;
  logic [NUM_ENTRIES-1:0]   issue_req, issue_gnt;
  logic [INDEX_WIDTH-1:0]   gnt_idx;
  logic                     issue_fire, accept, merge, alloc, merge_fill;
  logic [THREADS-1:0]       thr_bit;

  always_comb begin
    any_free  = 1'b0;
    free_idx  = '0;
    issue_req = '0;
    gnt_idx   = '0;
    for (int i = NUM_ENTRIES - 1; i >= 0; i--) begin
      if (entries_q[i].state == FREE) begin
        any_free = 1'b1;
        free_idx = INDEX_WIDTH'(i);
      end
    end
    for (int i = 0; i < NUM_ENTRIES; i++) begin
      issue_req[i] = (entries_q[i].state == WAIT_ISSUE);
      if (issue_gnt[i]) gnt_idx = INDEX_WIDTH'(i);
    end
  end

  miss_issue_arbiter #(.N(NUM_ENTRIES), .IW(INDEX_WIDTH)) u_arb (
    .clk    (clk),
    .rst    (reset),
    .req    (issue_req),
    .update (issue_fire),
    .grant  (issue_gnt)
  );

  // The fill owns the CAM write port, so a new allocation must wait out the fill cycle.
  assign miss_ready     = cam_lookup_hit || (any_free && !fill_en);
  assign accept         = miss_en && miss_ready;
  assign merge          = accept && cam_lookup_hit;
  assign alloc          = accept && !cam_lookup_hit;
  assign merge_fill     = merge && (cam_lookup_idx == fill_idx) && fill_en;
  assign thr_bit        = {{(THREADS-1){1'b0}}, 1'b1} << miss_thread;
  assign cam_lookup_key = miss_addr;
  assign l2_req_valid   = |issue_req;
  assign l2_req_idx     = gnt_idx;
  assign l2_req_addr    = entries_q[gnt_idx].addr;
  assign issue_fire     = l2_req_valid && l2_req_ready;
  assign full           = !any_free;
  assign wake_en        = wake_en_q;
  assign wake_bitmap    = wake_bitmap_q;

  always_comb begin
    entries_d        = entries_q;
    cam_update_en    = 1'b0;
    cam_update_valid = 1'b0;
    cam_update_key   = '0;
    cam_update_idx   = '0;
    wake_en_d        = fill_en;
    wake_bitmap_d    = '0;
    if (issue_fire) entries_d[gnt_idx].state = PENDING;
    if (merge) entries_d[cam_lookup_idx].waiters = entries_d[cam_lookup_idx].waiters | thr_bit;
    if (fill_en) begin
      wake_bitmap_d                = entries_q[fill_idx].waiters | ({THREADS{merge_fill}} & thr_bit);
      entries_d[fill_idx].state    = FREE;
      entries_d[fill_idx].waiters  = '0;
      cam_update_en                = 1'b1;
      cam_update_key               = entries_q[fill_idx].addr;
      cam_update_idx               = fill_idx;
    end else if (alloc) begin
      entries_d[free_idx].state    = WAIT_ISSUE;
      entries_d[free_idx].addr     = miss_addr;
      entries_d[free_idx].waiters  = thr_bit;
      cam_update_en                = 1'b1;
      cam_update_valid             = 1'b1;
      cam_update_key               = miss_addr;
      cam_update_idx               = free_idx;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NUM_ENTRIES; i++) begin
        entries_q[i].state   <= FREE;
        entries_q[i].addr    <= '0;
        entries_q[i].waiters <= '0;
      end
      wake_en_q     <= 1'b0;
      wake_bitmap_q <= '0;
    end else begin
      entries_q     <= entries_d;
      wake_en_q     <= wake_en_d;
      wake_bitmap_q <= wake_bitmap_d;
    end
  end

  assert property (@(posedge clk) disable iff (reset) fill_en |-> entries_q[fill_idx].state == PENDING);

`ifdef MISS_ALLOC_PERF_EN
  logic        perf_merge_q, perf_merge_d;
  logic        perf_alloc_q, perf_alloc_d;
  logic [31:0] stall_cnt_q, stall_cnt_d;

  always_comb begin
    perf_merge_d = merge;
    perf_alloc_d = alloc;
    stall_cnt_d  = stall_cnt_q;
    if (miss_en && !miss_ready && (stall_cnt_q != 32'hffff_ffff)) stall_cnt_d = stall_cnt_q + 32'd1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      perf_merge_q <= 1'b0;
      perf_alloc_q <= 1'b0;
      stall_cnt_q  <= '0;
    end else begin
      perf_merge_q <= perf_merge_d;
      perf_alloc_q <= perf_alloc_d;
      stall_cnt_q  <= stall_cnt_d;
    end
  end

  assign perf_miss_merge       = perf_merge_q;
  assign perf_miss_alloc       = perf_alloc_q;
  assign perf_miss_stall_count = stall_cnt_q;
`else
  assign perf_miss_merge       = 1'b0;
  assign perf_miss_alloc       = 1'b0;
  assign perf_miss_stall_count = 32'd0;
`endif
endmodule
